// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants and physical index helper
package regfile_pkg;

    localparam int NUM_PHYS_REGS = 4;
    localparam int PHYS_ADDR_W   = 2;
    localparam int DATA_W        = 8;
    localparam int ADDR_W        = 3;

    // Architectural addresses alias onto the physical registers through the low bits.
    function automatic logic [PHYS_ADDR_W-1:0] phys_idx(input logic [ADDR_W-1:0] addr);
        return addr[PHYS_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - requester, register-file write and reservation signals
interface regfile_write_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;

    logic                    rf_write_en;
    logic [ADDR_W-1:0]       rf_write_addr;
    logic [DATA_W-1:0]       rf_write_data;

    logic                    reserve_en;
    logic [ADDR_W-1:0]       reserve_addr;
    logic                    reserve_ok;
    logic [regfile_pkg::NUM_PHYS_REGS-1:0] busy;

    modport master (
        output req_valid, req_addr, req_data, reserve_en, reserve_addr,
        input  req_ready, rf_write_en, rf_write_addr, rf_write_data, reserve_ok, busy
    );

    modport slave (
        input  req_valid, req_addr, req_data, reserve_en, reserve_addr,
        output req_ready, rf_write_en, rf_write_addr, rf_write_data, reserve_ok, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin request picker starting at a priority pointer
module rr_arbiter #(
    parameter  int N     = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o
);

    int j;

    // Walk from the farthest candidate to the nearest so the last hit is the winner.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        j       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (req_i[j]) begin
                grant_o    = '0;
                grant_o[j] = 1'b1;
                idx_o      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin register-file write port sharing with busy scoreboard
module regfile_write_arbiter #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    regfile_write_arbiter_if.slave bus
);

    import regfile_pkg::*;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [IDX_W-1:0]         win_idx;
    logic [N_REQ-1:0]         grant;
    logic                     transfer;

    logic                     rf_en_q, rf_en_d;
    logic [ADDR_W-1:0]        rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]        rf_data_q, rf_data_d;

    logic [NUM_PHYS_REGS-1:0] busy_q, busy_d;
    logic [PHYS_ADDR_W-1:0]   res_p, clr_p;
    logic                     clr_hit;
    logic                     reserve_ok;

    rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx)
    );

    assign bus.req_ready = rst ? '0 : grant;
    assign transfer      = ~rst & (|grant);

    always_comb begin
        ptr_d = ptr_q;
        if (transfer) begin
            ptr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
    end

    always_comb begin
        rf_en_d   = transfer;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (transfer) begin
            rf_addr_d = bus.req_addr[win_idx*ADDR_W +: ADDR_W];
            rf_data_d = bus.req_data[win_idx*DATA_W +: DATA_W];
        end
    end

    // A write landing this cycle frees its register in time for a same-cycle reservation.
    assign res_p      = phys_idx(bus.reserve_addr);
    assign clr_p      = phys_idx(rf_addr_q);
    assign clr_hit    = rf_en_q & (clr_p == res_p);
    assign reserve_ok = bus.reserve_en & (~busy_q[res_p] | clr_hit);

    always_comb begin
        busy_d = busy_q;
        if (rf_en_q) begin
            busy_d[clr_p] = 1'b0;
        end
        if (reserve_ok) begin
            busy_d[res_p] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            rf_en_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            busy_q    <= '0;
        end else begin
            ptr_q     <= ptr_d;
            rf_en_q   <= rf_en_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.rf_write_en   = rf_en_q;
    assign bus.rf_write_addr = rf_addr_q;
    assign bus.rf_write_data = rf_data_q;
    assign bus.reserve_ok    = reserve_ok;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed and randomized checks against a behavioural model
module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_write_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int       m_ptr;
    bit [3:0] m_busy;
    bit       m_en;
    bit [AW-1:0] m_addr;
    bit [DW-1:0] m_data;
    int       last_win;
    logic     obs_ok;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Winner is the valid requester at the smallest circular distance from the pointer.
    function automatic int pick(input bit [N-1:0] v, input int ptr);
        int best = -1;
        int bd   = N;
        for (int i = 0; i < N; i++) begin
            int d = (i - ptr + N) % N;
            if (v[i] && d < bd) begin
                bd   = d;
                best = i;
            end
        end
        return best;
    endfunction

    task automatic set_req(input int i, input bit v, input int a, input int d);
        bus.req_valid[i]          = v;
        bus.req_addr[i*AW +: AW]  = AW'(a);
        bus.req_data[i*DW +: DW]  = DW'(d);
    endtask

    task automatic step();
        int        w;
        int        p;
        bit [N-1:0] er;
        bit        ok;
        #3;
        w  = rst ? -1 : pick(bus.req_valid, m_ptr);
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        p  = int'(bus.reserve_addr) % 4;
        ok = bus.reserve_en && (!m_busy[p] || (m_en && (int'(m_addr) % 4) == p));
        obs_ok = bus.reserve_ok;
        check("req_ready", 32'(bus.req_ready), 32'(er));
        check("reserve_ok", 32'(bus.reserve_ok), 32'(ok));
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_busy = '0; m_en = 0; m_addr = '0; m_data = '0;
        end else begin
            if (m_en) m_busy[int'(m_addr) % 4] = 1'b0;
            if (ok) m_busy[p] = 1'b1;
            if (w >= 0) begin
                m_en   = 1'b1;
                m_addr = bus.req_addr[w*AW +: AW];
                m_data = bus.req_data[w*DW +: DW];
                m_ptr  = (w + 1) % N;
            end else begin
                m_en = 1'b0;
            end
        end
        last_win = w;
        #1;
        check("rf_write_en", 32'(bus.rf_write_en), 32'(m_en));
        check("rf_write_addr", 32'(bus.rf_write_addr), 32'(m_addr));
        check("rf_write_data", 32'(bus.rf_write_data), 32'(m_data));
        check("busy", 32'(bus.busy), 32'(m_busy));
    endtask

    task automatic clear_inputs();
        bus.req_valid    = '0;
        bus.reserve_en   = 1'b0;
        bus.reserve_addr = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
    endtask

    initial begin
        m_ptr = 0; m_busy = '0; m_en = 0; m_addr = '0; m_data = '0; last_win = -1;
        rst = 1'b1;
        bus.req_addr = '0;
        bus.req_data = '0;
        clear_inputs();
        @(posedge clk);
        #1;
        step();
        check("rst_en", 32'(bus.rf_write_en), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        set_req(1, 1, 2, 8'hA5);
        step();
        check("single_win", 32'(last_win), 32'd1);
        check("single_en", 32'(bus.rf_write_en), 32'd1);
        check("single_addr", 32'(bus.rf_write_addr), 32'd2);
        check("single_data", 32'(bus.rf_write_data), 32'hA5);
        clear_inputs();
        step();
        check("single_idle", 32'(bus.rf_write_en), 32'd0);

        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1, i, 8'h10 + i);
        for (int k = 0; k < 6; k++) begin
            step();
            check("rr_order", 32'(last_win), 32'(k % 3));
            check("rr_data", 32'(bus.rf_write_data), 32'(8'h10 + k % 3));
        end
        clear_inputs();

        bus.reserve_en = 1'b1; bus.reserve_addr = 3'd1;
        step();
        check("sb_res1_ok", 32'(obs_ok), 32'd1);
        check("sb_res1_busy", 32'(bus.busy), 32'b0010);
        step();
        check("sb_res2_ok", 32'(obs_ok), 32'd0);
        check("sb_res2_busy", 32'(bus.busy), 32'b0010);
        bus.reserve_en = 1'b0;
        set_req(0, 1, 1, 8'h33);
        step();
        clear_inputs();
        step();
        check("sb_clear", 32'(bus.busy), 32'd0);

        for (int r = 0; r < 2; r++) begin
            bus.reserve_en = 1'b1; bus.reserve_addr = 3'd3;
            step();
            bus.reserve_en = 1'b0;
            set_req(0, 1, 3, 8'h5A);
            step();
            clear_inputs();
            bus.reserve_en = 1'b1; bus.reserve_addr = (r == 0) ? 3'd3 : 3'd7;
            step();
            check("same_cycle_ok", 32'(obs_ok), 32'd1);
            check("same_cycle_busy", 32'(bus.busy), 32'b1000);
            clear_inputs();
            set_req(0, 1, 3, 8'h00);
            step();
            clear_inputs();
            step();
        end

        set_req(2, 1, 5, 8'hC3);
        step();
        check("mid_win", 32'(last_win), 32'd2);
        do_reset();
        check("mid_rst_en", 32'(bus.rf_write_en), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < N; i++) set_req(i, 1, i, 8'h40 + i);
        step();
        check("post_rst_win", 32'(last_win), 32'd0);

        do_reset();
        set_req(0, 1, 0, 8'h01); set_req(1, 1, 1, 8'h02);
        step();
        check("wd_win0", 32'(last_win), 32'd0);
        clear_inputs();
        step();
        check("wd_none", 32'(bus.rf_write_en), 32'd0);
        set_req(0, 1, 0, 8'h01); set_req(1, 1, 1, 8'h02);
        step();
        check("wd_win1", 32'(last_win), 32'd1);

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(bus.req_valid[i] && last_win != i && $urandom_range(0, 4) != 0)) begin
                    set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 255)));
                end
            end
            bus.reserve_en   = 1'($urandom_range(0, 1));
            bus.reserve_addr = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port among N_REQ writeback requesters: ALU, load unit, debug/loader.
- Arbitrates round-robin with valid/ready handshake and registers the winning write onto the register file write port.
- Keeps a 4-entry busy scoreboard. The issue stage reserves a destination register; the arbiter clears the reservation when that register's write reaches the register file.
- Sits between the execute/writeback units and the register file.

Parameters:
- N_REQ, 3, number of write requesters (2..4); index 0 has highest priority after reset.
- DATA_W, 8, register data width.
- ADDR_W, 3, architectural register address width; only bits [1:0] are physical.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester write request.
- req_addr  in  N_REQ*ADDR_W  packed destination addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_data  in  N_REQ*DATA_W  packed write data, same packing.
- req_ready  out  N_REQ  one-hot grant; a transfer occurs when valid&ready.
- rf_write_en  out  1  to register file write_en.
- rf_write_addr  out  ADDR_W  to register file write_addr.
- rf_write_data  out  DATA_W  to register file write_data.
- reserve_en  in  1  issue stage reserves a destination register.
- reserve_addr  in  ADDR_W  register to reserve; bits [1:0] used.
- reserve_ok  out  1  combinational; high when the reservation is accepted this cycle.
- busy  out  4  scoreboard; bit r = register r has a pending write.

Behaviour:
- Reset (rst=1 at clk edge):
  - rf_write_en=0, rf_write_addr=0, rf_write_data=0, busy=0, priority pointer=0.
  - req_ready=0 while rst is high. Reset mid-transfer discards any pending output write.
- Arbitration (combinational, rst=0):
  - Search req_valid starting at pointer, wrapping modulo N_REQ; the first set bit wins.
  - req_ready is one-hot on the winner, else 0.
  - req_ready does not depend on busy; the write port accepts every cycle.
- Pointer update: on a transfer by requester g, pointer <= (g+1) mod N_REQ. With no transfer, the pointer holds.
- Output stage, 1-cycle latency:
  - On a transfer: rf_write_en<=1, rf_write_addr<=req_addr[g], rf_write_data<=req_data[g].
  - Otherwise rf_write_en<=0 and addr/data hold their last values.
  - Throughput: one write per cycle, back-to-back allowed.
- Requester contract: valid, addr and data are held stable until ready; a violation is undefined. Dropping valid without ready is allowed.
- Scoreboard (physical index p = addr[1:0]):
  - Clear: when rf_write_en=1, busy[rf_write_addr[1:0]] <= 0.
  - Reserve: reserve_ok = reserve_en & ~busy[p]. When reserve_ok=1, busy[p] <= 1. When reserve_en=1 and busy[p]=1, the reservation is ignored (reserve_ok=0) and the issue stage must stall.
  - Same-cycle clear and reserve of the same register: reserve_ok=1 (the busy bit is read pre-clear, so this is treated as a conflict)? No — clear wins the check: reserve_ok = reserve_en & (~busy[p] | (rf_write_en & rf_write_addr[1:0]==p)). busy[p] ends at 1 (reserve wins over clear).
  - Clear and reserve of different registers in the same cycle are independent.
  - A write to a register that is not busy is legal and leaves busy unchanged.
- Address aliasing: addresses 4..7 alias to 0..3 in the scoreboard. rf_write_addr passes the full ADDR_W value through unchanged.

Decomposition:
- Shared package regfile_pkg holds:
  - localparams NUM_PHYS_REGS=4, PHYS_ADDR_W=2, DATA_W=8, ADDR_W=3;
  - function phys_idx(addr) returning addr[1:0].
- One natural sub-module: rr_arbiter (N parameter; inputs req and pointer; outputs one-hot grant and encoded index), reusable by later bus arbiters.
- The scoreboard and output register stay inline.

Test Plan:
- Reset, then single request: after rst, req_valid=3'b010, addr=2, data=8'hA5 -> req_ready=3'b010 the same cycle; next cycle rf_write_en=1, addr=2, data=A5; the following cycle rf_write_en=0.
- Round-robin fairness: all three valid continuously for 6 cycles -> grant order 0,1,2,0,1,2; rf_write_data stream matches that order with 1-cycle lag.
- Scoreboard lifecycle:
  - reserve addr=1 -> reserve_ok=1, busy=4'b0010;
  - second reserve addr=1 -> reserve_ok=0, busy unchanged;
  - write to R1 granted -> busy=0 the cycle after rf_write_en.
- Same-cycle clear and reserve: rf_write_en=1 to R3 while reserve_en addr=3 -> reserve_ok=1, busy[3] stays 1. Repeat with reserve addr=7 -> identical result (aliasing).
- Reset mid-operation: grant requester 2, then assert rst on the next edge -> rf_write_en=0, busy=0, pointer=0. With all valid after release, requester 0 wins first.
- Valid withdrawn: requester 1 drops valid while requester 0 is being granted -> no write for requester 1; the pointer advances only on actual transfers.
